// File: rtl/marker_sync_tracker.sv
`default_nettype none
// ============================================================================
// Module   : marker_sync_tracker
// Purpose  : Pairs phase START/END markers committed by a base and a variant
//            core through per-side FIFOs; tracks phase timing and divergence.
// Revision : 1.0 - initial release
// ============================================================================
module marker_sync_tracker #(
   parameter int NCHAN  = 2,
   parameter int NPHASE = 7,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NCHAN-1:0]              base_valid,
   input  logic [32*NCHAN-1:0]           base_inst,
   input  logic [NCHAN-1:0]              vnt_valid,
   input  logic [32*NCHAN-1:0]           vnt_inst,
   output logic [NPHASE-1:0]             phase_active_base,
   output logic [NPHASE-1:0]             phase_active_vnt,
   output logic                          evt_valid,
   output logic [$clog2(2*NPHASE)-1:0]   evt_code,
   output logic                          sync,
   output logic                          diverge,
   output logic [$clog2(2*NPHASE)-1:0]   div_code_base,
   output logic [$clog2(2*NPHASE)-1:0]   div_code_vnt,
   output logic                          overflow,
   output logic                          err_pair,
   output logic                          multi_drop,
   input  logic [$clog2(NPHASE)-1:0]     cyc_sel,
   output logic [CNT_W-1:0]              cyc_base,
   output logic [CNT_W-1:0]              cyc_vnt
);

   localparam int              c_CW    = $clog2(2*NPHASE);
   localparam int              c_PW    = $clog2(NPHASE);
   localparam int              c_AW    = $clog2(DEPTH);
   localparam logic [11:0]     c_NCODE = 12'(2*NPHASE);
   localparam logic [c_PW:0]   c_NPH   = (c_PW+1)'(NPHASE);

   // Side index 0 is the base core, 1 is the variant core.
   logic [1:0][NCHAN-1:0]    w_valid;
   logic [1:0][32*NCHAN-1:0] w_inst;
   logic [1:0]               w_empty;
   logic [1:0]               w_err;
   logic [1:0]               w_multi;
   logic [1:0]               w_ovf;
   logic [1:0][c_CW-1:0]     w_head;
   logic [1:0][NPHASE-1:0]   w_act;
   logic [1:0][CNT_W-1:0]    w_cyc;
   logic                     w_pop;

   assign w_valid = {vnt_valid, base_valid};
   assign w_inst  = {vnt_inst, base_inst};
   assign w_pop   = !w_empty[0] && !w_empty[1];

   for (genvar s = 0; s < 2; s++) begin : g_side
      logic [NCHAN-1:0]  w_is_mk;
      logic              w_found;
      logic              w_many;
      logic [c_CW-1:0]   w_code;
      logic [c_PW-1:0]   w_phase;
      logic              w_full;
      logic              w_push;
      logic [c_AW:0]     r_wr;
      logic [c_AW:0]     r_rd;
      logic [c_CW-1:0]   r_mem [DEPTH];
      logic [NPHASE-1:0] r_act;
      logic [CNT_W-1:0]  r_cnt [NPHASE];
      logic [CNT_W-1:0]  r_cyc;

      for (genvar i = 0; i < NCHAN; i++) begin : g_lane
         assign w_is_mk[i] = w_valid[s][i]
                          && (w_inst[s][32*i +: 20] == 20'h02013)
                          && (w_inst[s][32*i+20 +: 12] < c_NCODE);
      end

      // Only the oldest marker lane is honoured; any later one is a drop.
      always_comb begin
         w_found = 1'b0;
         w_many  = 1'b0;
         w_code  = '0;
         for (int i = 0; i < NCHAN; i++) begin
            if (w_is_mk[i]) begin
               if (w_found) begin
                  w_many = 1'b1;
               end else begin
                  w_found = 1'b1;
                  w_code  = w_inst[s][32*i+20 +: c_CW];
               end
            end
         end
      end

      assign w_phase    = w_code[c_CW-1:1];
      assign w_err[s]   = w_found && (w_code[0] ? !r_act[w_phase] : r_act[w_phase]);
      assign w_multi[s] = w_many;

      always_ff @(posedge clock) begin
         if (reset) begin
            r_act <= '0;
            r_cyc <= '0;
            for (int p = 0; p < NPHASE; p++) begin
               r_cnt[p] <= '0;
            end
         end else begin
            for (int p = 0; p < NPHASE; p++) begin
               if (r_act[p] && (r_cnt[p] != '1)) begin
                  r_cnt[p] <= r_cnt[p] + 1'b1;
               end
            end
            if (w_found) begin
               if (!w_code[0]) begin
                  r_act[w_phase] <= 1'b1;
                  r_cnt[w_phase] <= '0;
               end else if (r_act[w_phase]) begin
                  r_act[w_phase] <= 1'b0;
               end
            end
            r_cyc <= ({1'b0, cyc_sel} < c_NPH) ? r_cnt[cyc_sel] : '0;
         end
      end

      assign w_act[s] = r_act;
      assign w_cyc[s] = r_cyc;

      // A full FIFO may still accept a push when its head leaves this cycle.
      assign w_empty[s] = (r_wr == r_rd);
      assign w_full     = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
      assign w_push     = w_found && (!w_full || w_pop);
      assign w_ovf[s]   = w_found && w_full && !w_pop;
      assign w_head[s]  = r_mem[r_rd[c_AW-1:0]];

      always_ff @(posedge clock) begin
         if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
         end else begin
            if (w_push) begin
               r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
               r_rd <= r_rd + 1'b1;
            end
         end
      end

      always_ff @(posedge clock) begin
         if (!reset && w_push) begin
            r_mem[r_wr[c_AW-1:0]] <= w_code;
         end
      end
   end

   assign sync              = w_empty[0] & w_empty[1];
   assign phase_active_base = w_act[0];
   assign phase_active_vnt  = w_act[1];
   assign cyc_base          = w_cyc[0];
   assign cyc_vnt           = w_cyc[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         evt_valid     <= 1'b0;
         evt_code      <= '0;
         diverge       <= 1'b0;
         div_code_base <= '0;
         div_code_vnt  <= '0;
         overflow      <= 1'b0;
         err_pair      <= 1'b0;
         multi_drop    <= 1'b0;
      end else begin
         evt_valid <= w_pop;
         if (w_pop) begin
            evt_code <= w_head[0];
            if ((w_head[0] != w_head[1]) && !diverge) begin
               diverge       <= 1'b1;
               div_code_base <= w_head[0];
               div_code_vnt  <= w_head[1];
            end
         end
         overflow   <= overflow   | (|w_ovf);
         err_pair   <= err_pair   | (|w_err);
         multi_drop <= multi_drop | (|w_multi);
      end
   end

endmodule
`default_nettype wire
